// File: rtl/fc_ctrl_pkg.sv
// fc_ctrl_pkg -- shared types and width helpers for the fully-connected layer
// controller.
//   fc_ctrl_state_t : controller FSM states (load words, bias fetch, bias add,
//                     drain results)
//   addr_w(h)       : weight/bias ROM address width for h input words (+1 bias slot)
//   idx_w(l)        : neuron index width for l neurons (min 1 bit)
package fc_ctrl_pkg;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_BIAS  = 2'd1,
      S_ADD   = 2'd2,
      S_DRAIN = 2'd3
   } fc_ctrl_state_t;

   function automatic int addr_w(input int h);
      return $clog2(h + 1);
   endfunction

   function automatic int idx_w(input int l);
      return (l > 1) ? $clog2(l) : 1;
   endfunction

endpackage

// File: rtl/fc_layer_ctrl_drain.sv
// fc_drain_mux -- result serializer datapath for fc_layer_ctrl.
// Selects one neuron sum by index, optionally clamps negatives to zero, and
// flags the final word of the frame.
//   en    : in  - drain phase active (qualifies last)
//   idx   : in  - neuron index being presented
//   sums  : in  - all neuron results, packed LAYER_HEIGHT x WORD_SIZE
//   data  : out - selected (optionally rectified) word
//   last  : out - en and idx is the final neuron
// Build option: define FC_LAYER_CTRL_RELU_EN to clamp negative sums to 0.
module fc_drain_mux import fc_ctrl_pkg::*; #(
   parameter int WORD_SIZE    = 16,
   parameter int LAYER_HEIGHT = 2
) (
   input  logic                                       en,
   input  logic [idx_w(LAYER_HEIGHT)-1:0]             idx,
   input  logic signed [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] sums,
   output logic signed [WORD_SIZE-1:0]                data,
   output logic                                       last
);

   localparam int IW = idx_w(LAYER_HEIGHT);
   localparam logic [IW-1:0] IDX_LAST = IW'(LAYER_HEIGHT - 1);

   logic [WORD_SIZE-1:0] sel;

   assign sel = sums[idx];

`ifdef FC_LAYER_CTRL_RELU_EN
   assign data = sel[WORD_SIZE-1] ? '0 : sel;
`else
   assign data = sel;
`endif

   assign last = en && (idx == IDX_LAST);

endmodule

// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl -- sequencer for one fully-connected layer.
// Accepts PREVIOUS_LAYER_HEIGHT words per frame, broadcasts each to the neurons
// with a one-cycle-late accumulate strobe, fetches and adds the bias, then
// serializes the LAYER_HEIGHT neuron results downstream.
//   clk_i, reset_i           : clock, synchronous active-high reset
//   data_i/valid_i/ready_o   : upstream word stream
//   neuron_data_o            : registered broadcast word
//   mem_addr_o               : weight/bias ROM address (0..H-1 weights, H = bias)
//   sum_en_o/add_bias_o/acc_clr_o : neuron accumulator controls
//   neuron_sum_i             : neuron results
//   data_o/valid_o/last_o/ready_i : downstream result stream
// Build option: FC_LAYER_CTRL_RELU_EN (rectify results, see fc_drain_mux).
module fc_layer_ctrl import fc_ctrl_pkg::*; #(
   parameter int WORD_SIZE             = 16,
   parameter int PREVIOUS_LAYER_HEIGHT = 4,
   parameter int LAYER_HEIGHT          = 2
) (
   input  logic                                          clk_i,
   input  logic                                          reset_i,
   input  logic signed [WORD_SIZE-1:0]                   data_i,
   input  logic                                          valid_i,
   output logic                                          ready_o,
   output logic signed [WORD_SIZE-1:0]                   neuron_data_o,
   output logic [addr_w(PREVIOUS_LAYER_HEIGHT)-1:0]      mem_addr_o,
   output logic                                          sum_en_o,
   output logic                                          add_bias_o,
   output logic                                          acc_clr_o,
   input  logic signed [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] neuron_sum_i,
   output logic signed [WORD_SIZE-1:0]                   data_o,
   output logic                                          valid_o,
   output logic                                          last_o,
   input  logic                                          ready_i
);

   localparam int AW = addr_w(PREVIOUS_LAYER_HEIGHT);
   localparam int IW = idx_w(LAYER_HEIGHT);
   localparam logic [AW-1:0] CNT_LAST  = AW'(PREVIOUS_LAYER_HEIGHT - 1);
   localparam logic [AW-1:0] ADDR_BIAS = AW'(PREVIOUS_LAYER_HEIGHT);

   fc_ctrl_state_t state;
   logic [AW-1:0]  cnt;
   logic [IW-1:0]  idx;
   logic           sum_en_q;
   logic           clr_q;
   logic           xfer;
   logic           hs;

   // Strobes are gated by reset so the neurons see nothing while reset is held,
   // even in the cycle before the registers have been cleared.
   assign ready_o    = (state == S_LOAD) && !reset_i;
   assign valid_o    = (state == S_DRAIN) && !reset_i;
   assign add_bias_o = (state == S_ADD) && !reset_i;
   assign sum_en_o   = sum_en_q && !reset_i;
   assign acc_clr_o  = clr_q && !reset_i;
   assign mem_addr_o = (state == S_LOAD) ? cnt : ADDR_BIAS;

   assign xfer = valid_i && ready_o;
   assign hs   = valid_o && ready_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state         <= S_LOAD;
         cnt           <= '0;
         idx           <= '0;
         neuron_data_o <= '0;
         sum_en_q      <= 1'b0;
         // Held high so the first cycle out of reset clears the accumulators.
         clr_q         <= 1'b1;
      end else begin
         // Weight ROM has one cycle of latency, so accumulate the cycle after
         // the word is latched.
         sum_en_q <= xfer;
         clr_q    <= hs && last_o;
         case (state)
            S_LOAD: begin
               if (xfer) begin
                  neuron_data_o <= data_i;
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= S_BIAS;
                  end else begin
                     cnt <= cnt + AW'(1);
                  end
               end
            end
            S_BIAS: state <= S_ADD;
            S_ADD:  state <= S_DRAIN;
            S_DRAIN: begin
               if (hs) begin
                  if (last_o) begin
                     idx   <= '0;
                     state <= S_LOAD;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

   fc_drain_mux #(
      .WORD_SIZE    (WORD_SIZE),
      .LAYER_HEIGHT (LAYER_HEIGHT)
   ) u_drain (
      .en   (valid_o),
      .idx  (idx),
      .sums (neuron_sum_i),
      .data (data_o),
      .last (last_o)
   );

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl -- scoreboard bench for fc_layer_ctrl (H=4, L=2).
// Driver issues frames (directed and random); a negedge monitor keeps a
// frame-level model (words accepted, outputs owed) and checks every cycle.
module tb_fc_layer_ctrl;
   localparam int W = 16;
   localparam int H = 4;
   localparam int L = 2;

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   logic valid_i = 1'b0;
   logic ready_i = 1'b0;
   logic signed [W-1:0] data_i = '0;
   logic signed [L-1:0][W-1:0] ns = '0;
   logic ready_o, sum_en_o, add_bias_o, acc_clr_o, valid_o, last_o;
   logic signed [W-1:0] neuron_data_o, data_o;
   logic [2:0] mem_addr_o;

   always #5 clk = ~clk;

   fc_layer_ctrl #(.WORD_SIZE(W), .PREVIOUS_LAYER_HEIGHT(H), .LAYER_HEIGHT(L)) dut (
      .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .neuron_data_o(neuron_data_o), .mem_addr_o(mem_addr_o), .sum_en_o(sum_en_o),
      .add_bias_o(add_bias_o), .acc_clr_o(acc_clr_o), .neuron_sum_i(ns), .data_o(data_o),
      .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic measure = 1'b0;

   typedef struct packed { logic [W-1:0] d; logic l; } out_t;
   logic [W-1:0] word_q[$];
   out_t out_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_out(input logic [W-1:0] x);
`ifdef FC_LAYER_CTRL_RELU_EN
      return x[W-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   // ---------------- monitor / reference model ----------------
   int   exp_cnt = 0;    // words accepted in current frame
   int   stage = 0;      // 1: bias fetch cycle due, 2: bias add cycle due
   int   sum_cnt = 0;
   int   last_clr = -1;
   bit   prev_xfer = 0, clr_due = 0, rst_prev = 0, hold_v = 0, hold_l = 0;
   logic [W-1:0] hold_d;

   always @(negedge clk) begin
      cyc++;
      if (reset_i) begin
         chk("rst_ready", 32'(ready_o), 0);
         chk("rst_valid", 32'(valid_o), 0);
         chk("rst_sum_en", 32'(sum_en_o), 0);
         chk("rst_add_bias", 32'(add_bias_o), 0);
         chk("rst_acc_clr", 32'(acc_clr_o), 0);
         chk("rst_last", 32'(last_o), 0);
         word_q.delete();
         out_q.delete();
         exp_cnt = 0; stage = 0; sum_cnt = 0; prev_xfer = 0;
         clr_due = 1; rst_prev = 1; hold_v = 0; last_clr = -1;
      end else begin
         if (rst_prev) begin
            chk("rst_ndata", 32'($unsigned(neuron_data_o)), 0);
            chk("rst_addr", 32'(mem_addr_o), 0);
         end
         chk("acc_clr", 32'(acc_clr_o), 32'(clr_due));
         if (acc_clr_o && measure && last_clr >= 0)
            chk("period", 32'(cyc - last_clr), 32'(H + 2 + L));
         if (acc_clr_o) last_clr = measure ? cyc : -1;
         clr_due = 0;

         chk("sum_en", 32'(sum_en_o), 32'(prev_xfer));
         if (sum_en_o) begin
            sum_cnt++;
            if (word_q.size() != 0)
               chk("ndata", 32'($unsigned(neuron_data_o)), 32'(word_q.pop_front()));
         end
         chk("ready", 32'(ready_o), 32'(exp_cnt < H));
         chk("add_bias", 32'(add_bias_o), 32'(stage == 2));
         if (stage == 1) chk("bias_addr", 32'(mem_addr_o), 32'(H));
         chk("valid", 32'(valid_o), 32'(out_q.size() != 0));
         if (hold_v) begin
            chk("hold_data", 32'($unsigned(data_o)), 32'(hold_d));
            chk("hold_last", 32'(last_o), 32'(hold_l));
         end
         hold_v = 0;

         // advance model
         if (stage == 2) begin
            chk("sum_count", 32'(sum_cnt), 32'(H));
            for (int k = 0; k < L; k++) out_q.push_back('{d: ref_out(ns[k]), l: (k == L - 1)});
            stage = 0;
            sum_cnt = 0;
         end else if (stage == 1) begin
            stage = 2;
         end

         prev_xfer = valid_i && ready_o;
         if (prev_xfer) begin
            chk("addr", 32'(mem_addr_o), 32'(exp_cnt));
            word_q.push_back(data_i);
            exp_cnt++;
            if (exp_cnt == H) stage = 1;
         end

         if (valid_o && out_q.size() != 0) begin
            if (ready_i) begin
               out_t e;
               e = out_q.pop_front();
               chk("data_o", 32'($unsigned(data_o)), 32'(e.d));
               chk("last_o", 32'(last_o), 32'(e.l));
               if (e.l) begin
                  exp_cnt = 0;
                  clr_due = 1;
               end
            end else begin
               hold_v = 1;
               hold_d = data_o;
               hold_l = last_o;
            end
         end
         rst_prev = 0;
      end
   end

   // ---------------- driver ----------------
   task automatic run_frame(input bit fixed, input int bub, input int stall,
                            input int hold1, input int stall_n, input int rst_after);
      logic [W-1:0] w [H];
      int sent = 0;
      int holds = hold1;
      int stalls = stall_n;
      int it = 0;
      bit done = 0;
      for (int k = 0; k < H; k++) w[k] = fixed ? W'((k + 1) * 256) : W'($urandom);
      while (!done) begin
         @(posedge clk); #1;
         if (rst_after >= 0 && sent == rst_after) begin
            valid_i = 0;
            reset_i = 1;
            @(posedge clk); #1;
            reset_i = 0;
            return;
         end
         if (sent == 2 && holds > 0) begin
            valid_i = 0;
            holds--;
         end else begin
            valid_i = (sent < H) && ($urandom_range(99) >= bub);
         end
         data_i = W'($urandom);
         if (valid_i && sent < H) data_i = w[sent];
         if (valid_o && stalls > 0) begin
            ready_i = 0;
            stalls--;
         end else begin
            ready_i = ($urandom_range(99) >= stall);
         end
         @(negedge clk);
         if (valid_i && ready_o) sent++;
         if (valid_o && ready_i && last_o) done = 1;
         it++;
         if (it > 400) begin
            chk("frame_timeout", 1, 0);
            done = 1;
         end
      end
   endtask

   task automatic new_ns();
      #2;
      ns[0] = W'($urandom);
      ns[1] = W'($urandom);
   endtask

   initial begin
      reset_i = 1;
      repeat (3) @(posedge clk);
      #1 reset_i = 0;

      // plain frame; ns[0] negative to exercise the rectifier option
      ns[0] = 16'hFF00;
      ns[1] = 16'h0042;
      run_frame(1, 0, 0, 0, 0, -1);
      // valid_i bubbles after word 1
      #2 ns[0] = 16'h7FFF; ns[1] = 16'h8001;
      run_frame(1, 0, 0, 3, 0, -1);
      // downstream stall in drain
      new_ns();
      run_frame(1, 0, 0, 0, 5, -1);
      // abort after two words, then a fresh frame
      run_frame(1, 0, 0, 0, 0, 2);
      run_frame(1, 0, 0, 0, 0, -1);
      // back-to-back frames, period measured between acc_clr pulses
      #2 measure = 1;
      run_frame(0, 0, 0, 0, 0, -1);
      run_frame(0, 0, 0, 0, 0, -1);
      @(negedge clk);
      #1 measure = 0;

      repeat (40) begin
         new_ns();
         run_frame(0, $urandom_range(40), $urandom_range(40), 0, 0,
                   ($urandom_range(9) == 0) ? int'($urandom_range(H - 1)) : -1);
      end
      @(posedge clk); #1;
      valid_i = 0;
      ready_i = 0;
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
